mul_share_ctrl: RTL and testbench
=================================

// Module: mul_share_ctrl
// PURPOSE
//  Sequencer and 2-way arbiter for the repeated-addition multiplier datapath (mul_datapath).
//  Accepts multiply requests from two clients and grants the datapath round-robin.
//  Drives operands over the datapath's single data_in bus: A first, then B.
//  Sequences LdA/LdB/LdP/clrP/decB until eqz, then returns the product with a one-cycle ack.
// PARAMETERS
//  WIDTH  16  operand/product width; must match mul_datapath
// PORTS
//  clk       in   1        system clock, rising edge
//  rst       in   1        asynchronous reset, active-high
//  req       in   2        per-client request; held high until matching ack[i]
//  opa0,opb0 in   WIDTH    client 0 operands, stable while req[0] high
//  opa1,opb1 in   WIDTH    client 1 operands, stable while req[1] high
//  ack       out  2        one-cycle pulse on ack[owner]; product valid this cycle
//  prod      out  WIDTH    product; valid only when |ack
//  busy      out  1        high in any state other than IDLE
//  data_in   out  WIDTH    operand bus to datapath
//  LdA,LdB,LdP,clrP,decB  out 1  datapath controls
//  eqz       in   1        datapath B-register==0 flag (combinational on B reg)
//  Y         in   WIDTH    datapath product register
// BEHAVIOUR
//  Reset (async): state=IDLE, owner=0, last=1 (client 0 wins first), a_q=b_q=0.
//   All outputs 0 while rst high and in IDLE.
//  IDLE: sample req. If any req is high, grant via round-robin:
//   - only one req high -> that client
//   - both high -> client != last
//   - latch owner, a_q/b_q <= owner's operands; last <= owner; next state LDA.
//  LDA: data_in=a_q, LdA=1 -> LDB.
//  LDB: data_in=b_q, LdB=1, clrP=1 -> ADD.
//  ADD:
//   - eqz=0 -> LdP=1, decB=1, stay in ADD
//   - eqz=1 -> no controls asserted, go to DONE
//  DONE: ack[owner]=1, prod=Y (Moore outputs) -> IDLE.
//  data_in = 0 outside LDA/LDB. Control outputs are Moore decodes of state; never two Ld* in one cycle.
//  Latency: req sampled at edge k -> ack high in the cycle after edge k+b+3 (b = operand B).
//   b=0 gives 3 ADD-free cycles before DONE: ADD lasts one cycle with eqz=1.
//  Throughput: back-to-back grants possible; IDLE is re-entered for exactly one cycle between jobs.
//  Width: product wraps mod 2^WIDTH; no overflow flag.
//  Client protocol:
//   - client drops req in the cycle after its ack
//   - req still high in the IDLE cycle after ack is treated as a new request
//   - ack cycle clearing is the client's job
//  Requests arriving mid-job are ignored until IDLE; they are not lost as long as req is held.
//  Operand changes after grant have no effect (operands are latched).
//  Reset mid-job: abort immediately to reset state, no ack. Datapath contents are don't-care.
//  eqz is ignored in all states except ADD.
// STRUCTURE
//  Shared header mul_defs.vh:
//   - state localparams IDLE=0, LDA=1, LDB=2, ADD=3, DONE=4 (3-bit)
//   - MUL_WIDTH default 16
//  Sub-module rr_arb2 (combinational): inputs req[1:0], last -> grant_valid, grant_id.
//  Top level holds FSM, owner/last registers, operand latches and output decode. Target ~150-200 lines.
// TESTING
//  Bench instantiates mul_share_ctrl + mul_datapath, clk period 10.
//  1 Single client: req[0], A=10, B=5 -> ack[0] one cycle, prod=50, ack 8 cycles after req sampled.
//  2 Zero operand: req[1], A=7, B=0 -> ack[1], prod=0, latency 3; LdP/decB never asserted.
//  3 Contention:
//     - both req high after reset (0: 3x4, 1: 6x2) -> client 0 first (12), then client 1 (12)
//     - client 0 re-requests -> grants alternate 0,1,0
//  4 Wrap: A=16'h8000, B=3 -> prod=16'h8000 (mod 2^16), single ack.
//  5 Reset mid-ADD: assert rst during job A=9, B=9 -> outputs 0 immediately, no ack, busy=0.
//     Next request 2x3 -> prod=6.
//  6 Operand change after grant: change opb0 during LDB -> result uses latched value.
//  Checkers:
//   - ack onehot0
//   - prod checked only on ack
//   - at most one of LdA/LdB/LdP per cycle
//   - busy==(state!=IDLE)

Source files
------------

// File: rtl/mul_share_ctrl_pkg.sv
// mul_share_ctrl_pkg: shared state encodings, default width and client helpers
// for the shared repeated-addition multiplier controller.
package mul_share_ctrl_pkg;

    localparam int MUL_WIDTH = 16;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LDA  = 3'd1;
    localparam logic [2:0] LDB  = 3'd2;
    localparam logic [2:0] ADD  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    function automatic logic [1:0] client_mask(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mul_share_ctrl_if.sv
// mul_share_ctrl_if: client request/ack bus plus the datapath control bus.
// master is the controller's view; slave is the clients' and datapath's view.
interface mul_share_ctrl_if import mul_share_ctrl_pkg::*; #(parameter int WIDTH = MUL_WIDTH);

    logic [1:0]       req;
    logic [1:0]       ack;
    logic [WIDTH-1:0] opa0;
    logic [WIDTH-1:0] opb0;
    logic [WIDTH-1:0] opa1;
    logic [WIDTH-1:0] opb1;
    logic [WIDTH-1:0] prod;
    logic             busy;
    logic [WIDTH-1:0] data_in;
    logic             LdA;
    logic             LdB;
    logic             LdP;
    logic             clrP;
    logic             decB;
    logic             eqz;
    logic [WIDTH-1:0] Y;

    modport master (
        input  req, opa0, opb0, opa1, opb1, eqz, Y,
        output ack, prod, busy, data_in, LdA, LdB, LdP, clrP, decB
    );

    modport slave (
        output req, opa0, opb0, opa1, opb1, eqz, Y,
        input  ack, prod, busy, data_in, LdA, LdB, LdP, clrP, decB
    );

endinterface

// File: rtl/mul_datapath.sv
// mul_datapath: repeated-addition multiplier datapath (A, B down-counter,
// product accumulator) driven by mul_share_ctrl.
module mul_datapath import mul_share_ctrl_pkg::*; #(parameter int WIDTH = MUL_WIDTH) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             LdA,
    input  logic             LdB,
    input  logic             LdP,
    input  logic             clrP,
    input  logic             decB,
    output logic             eqz,
    output logic [WIDTH-1:0] Y
);

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] p_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r <= '0;
            b_r <= '0;
            p_r <= '0;
        end else begin
            if (LdA)
                a_r <= data_in;
            if (LdB)
                b_r <= data_in;
            else if (decB)
                b_r <= b_r - 1'b1;
            if (clrP)
                p_r <= '0;
            else if (LdP)
                p_r <= p_r + a_r;
        end
    end

    assign eqz = (b_r == '0);
    assign Y   = p_r;

endmodule

// File: rtl/mul_share_ctrl_rr_arb2.sv
// rr_arb2: combinational two-way round-robin arbiter; on contention the
// client that was not served last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant_valid,
    output logic       grant_id
);

    assign grant_valid = |req;
    assign grant_id    = (req == 2'b11) ? ~last : req[1];

endmodule

// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: round-robin sequencer that shares one repeated-addition
// multiplier datapath between two clients and returns products with an ack pulse.
module mul_share_ctrl import mul_share_ctrl_pkg::*; #(parameter int WIDTH = MUL_WIDTH) (
    input logic               clk,
    input logic               rst,
    mul_share_ctrl_if.master  bus
);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic             owner;
    logic             last;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             grant_valid;
    logic             grant_id;
    logic             grant;

    rr_arb2 u_arb (
        .req         (bus.req),
        .last        (last),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign grant = (state == IDLE) && grant_valid;

    always_comb begin
        state_nxt = (state == IDLE) ? (grant_valid ? LDA : IDLE) :
                    (state == LDA)  ? LDB :
                    (state == LDB)  ? ADD :
                    (state == ADD)  ? (bus.eqz ? DONE : ADD) :
                                      IDLE;
    end

    // Operands are latched at grant so clients may change them mid-job.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                owner <= grant_id;
                last  <= grant_id;
                a_q   <= grant_id ? bus.opa1 : bus.opa0;
                b_q   <= grant_id ? bus.opb1 : bus.opb0;
            end
        end
    end

    assign bus.LdA     = (state == LDA);
    assign bus.LdB     = (state == LDB);
    assign bus.clrP    = (state == LDB);
    assign bus.LdP     = (state == ADD) && !bus.eqz;
    assign bus.decB    = (state == ADD) && !bus.eqz;
    assign bus.data_in = (state == LDA) ? a_q : (state == LDB) ? b_q : '0;
    assign bus.ack     = (state == DONE) ? client_mask(owner) : 2'b00;
    assign bus.prod    = (state == DONE) ? bus.Y : '0;
    assign bus.busy    = (state != IDLE);

endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb_mul_share_ctrl: directed scenario bench for mul_share_ctrl driving a real
// mul_datapath, with per-cycle protocol invariants.
module tb_mul_share_ctrl;
    import mul_share_ctrl_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    logic ld_seen = 1'b0;

    mul_share_ctrl_if #(.WIDTH(W)) bus ();

    mul_share_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mul_datapath #(.WIDTH(W)) u_dp (
        .clk     (clk),
        .rst     (rst),
        .data_in (bus.data_in),
        .LdA     (bus.LdA),
        .LdB     (bus.LdB),
        .LdP     (bus.LdP),
        .clrP    (bus.clrP),
        .decB    (bus.decB),
        .eqz     (bus.eqz),
        .Y       (bus.Y)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.LdP || bus.decB)
            ld_seen = 1'b1;
        total_cnt++;
        if (!$onehot0(bus.ack))
            $display("FAIL ack_onehot0 ack=%b required onehot0", bus.ack);
        else
            pass_cnt++;
        total_cnt++;
        if ($countones({bus.LdA, bus.LdB, bus.LdP}) > 1)
            $display("FAIL ld_exclusive LdA/LdB/LdP=%b%b%b required at most one", bus.LdA, bus.LdB, bus.LdP);
        else
            pass_cnt++;
    end

    task automatic wait_ack(output logic [1:0] a, output logic [W-1:0] p, output int n);
        a = 2'b00;
        p = '0;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (bus.ack != 2'b00) begin
                a = bus.ack;
                p = bus.prod;
                return;
            end
        end
        n = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = 2'b00;
        bus.opa0 = '0; bus.opb0 = '0; bus.opa1 = '0; bus.opb1 = '0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({bus.ack, bus.busy, bus.LdA, bus.LdB, bus.LdP, bus.clrP, bus.decB} !== 9'd0 || bus.data_in !== '0 || bus.prod !== '0)
            $display("FAIL reset_outputs ack=%b busy=%b data_in=%h prod=%h required all 0", bus.ack, bus.busy, bus.data_in, bus.prod);
        else
            pass_cnt++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (bus.busy !== 1'b0 || bus.ack !== 2'b00 || bus.data_in !== '0)
            $display("FAIL idle_after_reset busy=%b ack=%b data_in=%h required 0", bus.busy, bus.ack, bus.data_in);
        else
            pass_cnt++;
    endtask

    task automatic test_single();
        logic [1:0] a; logic [W-1:0] p; int n;
        bus.opa0 = 16'd10; bus.opb0 = 16'd5; bus.req = 2'b01;
        wait_ack(a, p, n);
        bus.req = 2'b00;
        total_cnt++;
        if (a !== 2'b01) $display("FAIL single_ack ack=%b required 01", a); else pass_cnt++;
        total_cnt++;
        if (p !== 16'd50) $display("FAIL single_prod prod=%0d required 50", p); else pass_cnt++;
        total_cnt++;
        if (n - 1 !== 8) $display("FAIL single_latency latency=%0d required 8", n - 1); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bus.ack !== 2'b00 || bus.busy !== 1'b0)
            $display("FAIL single_ack_pulse ack=%b busy=%b required ack=00 busy=0", bus.ack, bus.busy);
        else
            pass_cnt++;
    endtask

    task automatic test_zero();
        logic [1:0] a; logic [W-1:0] p; int n;
        ld_seen = 1'b0;
        bus.opa1 = 16'd7; bus.opb1 = 16'd0; bus.req = 2'b10;
        wait_ack(a, p, n);
        bus.req = 2'b00;
        total_cnt++;
        if (a !== 2'b10) $display("FAIL zero_ack ack=%b required 10", a); else pass_cnt++;
        total_cnt++;
        if (p !== 16'd0) $display("FAIL zero_prod prod=%0d required 0", p); else pass_cnt++;
        total_cnt++;
        if (n - 1 !== 3) $display("FAIL zero_latency latency=%0d required 3", n - 1); else pass_cnt++;
        total_cnt++;
        if (ld_seen !== 1'b0) $display("FAIL zero_no_ldp ld_seen=%b required 0", ld_seen); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_contention();
        logic [1:0] a; logic [W-1:0] p; int n;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.opa0 = 16'd3; bus.opb0 = 16'd4;
        bus.opa1 = 16'd6; bus.opb1 = 16'd2;
        bus.req = 2'b11;
        wait_ack(a, p, n);
        bus.opa0 = 16'd5; bus.opb0 = 16'd5;
        total_cnt++;
        if (a !== 2'b01 || p !== 16'd12) $display("FAIL contend_first ack=%b prod=%0d required 01/12", a, p); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL contend_idle_gap busy=%b required 0", bus.busy); else pass_cnt++;
        wait_ack(a, p, n);
        bus.req = 2'b01;
        total_cnt++;
        if (a !== 2'b10 || p !== 16'd12) $display("FAIL contend_second ack=%b prod=%0d required 10/12", a, p); else pass_cnt++;
        wait_ack(a, p, n);
        bus.req = 2'b00;
        total_cnt++;
        if (a !== 2'b01 || p !== 16'd25) $display("FAIL contend_third ack=%b prod=%0d required 01/25", a, p); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [1:0] a; logic [W-1:0] p; int n;
        int extra = 0;
        bus.opa0 = 16'h8000; bus.opb0 = 16'd3; bus.req = 2'b01;
        wait_ack(a, p, n);
        bus.req = 2'b00;
        total_cnt++;
        if (a !== 2'b01 || p !== 16'h8000) $display("FAIL wrap_prod ack=%b prod=%h required 01/8000", a, p); else pass_cnt++;
        repeat (6) begin
            @(negedge clk);
            if (bus.ack != 2'b00) extra++;
        end
        total_cnt++;
        if (extra !== 0) $display("FAIL wrap_single_ack extra_acks=%0d required 0", extra); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [1:0] a; logic [W-1:0] p; int n;
        int stray = 0;
        bus.opa0 = 16'd9; bus.opb0 = 16'd9; bus.req = 2'b01;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({bus.ack, bus.busy, bus.LdA, bus.LdB, bus.LdP, bus.clrP, bus.decB} !== 9'd0 || bus.data_in !== '0 || bus.prod !== '0)
            $display("FAIL midreset_outputs ack=%b busy=%b LdP=%b data_in=%h required all 0", bus.ack, bus.busy, bus.LdP, bus.data_in);
        else
            pass_cnt++;
        bus.req = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (bus.ack != 2'b00 || bus.busy) stray++;
        end
        total_cnt++;
        if (stray !== 0) $display("FAIL midreset_no_ack stray_cycles=%0d required 0", stray); else pass_cnt++;
        bus.opa0 = 16'd2; bus.opb0 = 16'd3; bus.req = 2'b01;
        wait_ack(a, p, n);
        bus.req = 2'b00;
        total_cnt++;
        if (a !== 2'b01 || p !== 16'd6) $display("FAIL midreset_next ack=%b prod=%0d required 01/6", a, p); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_operand_change();
        logic [1:0] a; logic [W-1:0] p; int n;
        bus.opa0 = 16'd4; bus.opb0 = 16'd3; bus.req = 2'b01;
        @(negedge clk);
        @(negedge clk);
        total_cnt++;
        if (bus.LdB !== 1'b1 || bus.data_in !== 16'd3) $display("FAIL opchg_ldb LdB=%b data_in=%0d required 1/3", bus.LdB, bus.data_in); else pass_cnt++;
        bus.opa0 = 16'd9; bus.opb0 = 16'd7;
        wait_ack(a, p, n);
        bus.req = 2'b00;
        total_cnt++;
        if (a !== 2'b01 || p !== 16'd12) $display("FAIL opchg_prod ack=%b prod=%0d required 01/12", a, p); else pass_cnt++;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_zero();
        test_contention();
        test_wrap();
        test_reset_mid();
        test_operand_change();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
